// File: rtl/spi_flash_buffer_mock_pkg.sv
// Shared opcodes, dummy-cycle count and FSM state type for the SPI NOR flash mock.
package spi_flash_mock_pkg;

  localparam logic [7:0] OPC_READ      = 8'h03;
  localparam logic [7:0] OPC_FAST_READ = 8'h0B;
  localparam int         DUMMY_CYCLES  = 8;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    IGNORE
  } state_t;

endpackage

// File: rtl/spi_flash_buffer_mock_if.sv
// SPI pin bundle between flash controller (master) and flash mock (slave).
// so itself is a tri-state top-level port; so_oe exposes its drive enable.
interface spi_flash_buffer_mock_if;
  logic cs;
  logic sclk;
  logic si;
  logic wp;
  logic hold;
  logic so_oe;

  modport master (output cs, sclk, si, wp, hold, input  so_oe);
  modport slave  (input  cs, sclk, si, wp, hold, output so_oe);
endinterface

// File: rtl/spi_flash_buffer_mock_pin_sync.sv
// Two-flop synchronisers for the SPI pins plus edge pulses on the synced
// sclk and cs. The flops carry no reset: they must keep tracking the pins
// through a reset so a cs that stays low across reset is not mistaken for
// a fresh falling edge.
module spi_pin_sync (
  input  logic clk,
  input  logic cs,
  input  logic sclk,
  input  logic si,
  input  logic hold,
  output logic cs_s,
  output logic si_s,
  output logic hold_s,
  output logic cs_fall,
  output logic sclk_rise,
  output logic sclk_fall
);

  logic [1:0] cs_ff, sclk_ff, si_ff, hold_ff;
  logic       cs_d, sclk_d;

  // Synchronise pins and keep one extra history stage for edge detection
  always_ff @(posedge clk) begin
    cs_ff   <= {cs_ff[0], cs};
    sclk_ff <= {sclk_ff[0], sclk};
    si_ff   <= {si_ff[0], si};
    hold_ff <= {hold_ff[0], hold};
    cs_d    <= cs_ff[1];
    sclk_d  <= sclk_ff[1];
  end

  assign cs_s      = cs_ff[1];
  assign si_s      = si_ff[1];
  assign hold_s    = hold_ff[1];
  assign cs_fall   = cs_d & ~cs_ff[1];
  assign sclk_rise = ~sclk_d & sclk_ff[1];
  assign sclk_fall = sclk_d & ~sclk_ff[1];

endmodule

// File: rtl/spi_flash_buffer_mock.sv
// Read-only serial SPI NOR flash mock (mode 0) serving a flat bit-vector image.
// Supports READ (0x03); FAST_READ (0x0B, 8 dummy clocks) is added when
// FLASH_MOCK_FAST_READ_EN is defined, otherwise 0x0B is ignored like any
// unknown opcode.
module spi_flash_buffer_mock
  import spi_flash_mock_pkg::*;
#(
  parameter int BUFFER_SIZE = 8192,
  parameter int ADDR_BITS   = 24
) (
  input  logic                   clk,
  input  logic                   rstn,
  spi_flash_buffer_mock_if.slave bus,
  input  logic [BUFFER_SIZE-1:0] buffer,
  output wire                    so
);

  localparam int NBYTES = BUFFER_SIZE / 8;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CW     = (ADDR_BITS > 8) ? $clog2(ADDR_BITS) : 3;

  logic cs_s, si_s, hold_s, cs_fall, sclk_rise, sclk_fall;

  spi_pin_sync u_sync (
    .clk       (clk),
    .cs        (bus.cs),
    .sclk      (bus.sclk),
    .si        (bus.si),
    .hold      (bus.hold),
    .cs_s      (cs_s),
    .si_s      (si_s),
    .hold_s    (hold_s),
    .cs_fall   (cs_fall),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  // wp has no effect on a read-only device
  logic unused_wp;
  assign unused_wp = bus.wp;

  state_t                 state;
  logic [7:0]             cmd_sr;
  logic [ADDR_BITS-1:0]   addr_sr;
  logic [ADDR_BITS-1:0]   addr;
  logic [CW-1:0]          cnt;
  logic [2:0]             bit_idx;
  logic                   fast;
  logic                   drv;
  logic                   so_q;
  logic                   so_oe;

  logic [7:0]             cmd_nxt;
  logic [ADDR_BITS-1:0]   addr_nxt;
  assign cmd_nxt  = {cmd_sr[6:0], si_s};
  assign addr_nxt = {addr_sr[ADDR_BITS-2:0], si_s};

  // Byte view of the image; addresses past the image read as erased flash
  logic [NBYTES-1:0][7:0] mem;
  logic                   in_range;
  logic [7:0]             cur_byte;
  assign mem      = buffer;
  assign in_range = {1'b0, addr} < (ADDR_BITS+1)'(NBYTES);
  assign cur_byte = in_range ? mem[addr[IW-1:0]] : 8'hFF;

  // Command/address/data sequencer; cs high aborts, hold low freezes
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      cmd_sr  <= '0;
      addr_sr <= '0;
      addr    <= '0;
      cnt     <= '0;
      bit_idx <= '0;
      fast    <= 1'b0;
      drv     <= 1'b0;
      so_q    <= 1'b0;
    end else if (cs_s) begin
      state <= IDLE;
      cnt   <= '0;
      drv   <= 1'b0;
    end else if (hold_s) begin
      case (state)
        IDLE: if (cs_fall) begin
          state  <= CMD;
          cnt    <= '0;
          cmd_sr <= '0;
        end
        CMD: if (sclk_rise) begin
          cmd_sr <= cmd_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(7)) begin
            cnt <= '0;
            if (cmd_nxt == OPC_READ) begin
              state <= ADDR;
              fast  <= 1'b0;
            end
`ifdef FLASH_MOCK_FAST_READ_EN
            else if (cmd_nxt == OPC_FAST_READ) begin
              state <= ADDR;
              fast  <= 1'b1;
            end
`endif
            else begin
              state <= IGNORE;
            end
          end
        end
        ADDR: if (sclk_rise) begin
          addr_sr <= addr_nxt;
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(ADDR_BITS-1)) begin
            addr    <= addr_nxt;
            cnt     <= '0;
            bit_idx <= 3'd7;
            drv     <= 1'b0;
            state   <= fast ? DUMMY : DATA;
          end
        end
        DUMMY: if (sclk_rise) begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DUMMY_CYCLES-1)) begin
            cnt     <= '0;
            bit_idx <= 3'd7;
            state   <= DATA;
          end
        end
        DATA: if (sclk_fall) begin
          so_q    <= cur_byte[bit_idx];
          drv     <= 1'b1;
          bit_idx <= bit_idx - 1'b1;
          if (bit_idx == 3'd0) addr <= addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Drive so only once the first data bit is out and not while held
  assign so_oe     = (state == DATA) & drv & hold_s;
  assign bus.so_oe = so_oe;
  assign so        = so_oe ? so_q : 1'bz;

endmodule

// File: tb/tb_spi_flash_buffer_mock.sv
// Bench for spi_flash_buffer_mock: directed and randomized READ transfers
// checked against a byte-array image of the flash contents.
module tb_spi_flash_buffer_mock;

  localparam int BUFFER_SIZE = 8192;
  localparam int ADDR_BITS   = 24;
  localparam int NB          = BUFFER_SIZE / 8;
  localparam int HALF        = 4;

  logic                   clk  = 1'b0;
  logic                   rstn = 1'b0;
  logic [BUFFER_SIZE-1:0] buffer;
  wire                    so;

  spi_flash_buffer_mock_if bus ();

  spi_flash_buffer_mock #(
    .BUFFER_SIZE (BUFFER_SIZE),
    .ADDR_BITS   (ADDR_BITS)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .bus    (bus),
    .buffer (buffer),
    .so     (so)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] img [NB];

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    w = a & ((32'd1 << ADDR_BITS) - 32'd1);
    if (w < 32'(NB)) return img[w];
    return 8'hFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_cycle(input logic b, output logic r, output logic oe);
    bus.si = b;
    repeat (HALF) @(negedge clk);
    r  = so;
    oe = bus.so_oe;
    bus.sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    bus.sclk = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] opc, input logic [31:0] a, input int nabits);
    logic r, oe;
    bus.cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 7; i >= 0; i--) spi_cycle(opc[i], r, oe);
    for (int i = ADDR_BITS-1; i >= ADDR_BITS-nabits; i--) spi_cycle(a[i], r, oe);
  endtask

  task automatic read_byte(output logic [7:0] d, output logic all_oe);
    logic r, oe;
    all_oe = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      spi_cycle(1'($urandom_range(0, 1)), r, oe);
      d[i]   = r;
      all_oe = all_oe & oe;
    end
  endtask

  task automatic end_xfer(input string tag);
    repeat (HALF) @(negedge clk);
    bus.cs = 1'b1;
    repeat (HALF) @(negedge clk);
    check($sformatf("%s_oe_after_cs", tag), 32'(bus.so_oe), 32'd0);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    logic r, oe, any_oe;
    any_oe = 1'b0;
    for (int i = 0; i < n; i++) begin
      spi_cycle(1'($urandom_range(0, 1)), r, oe);
      any_oe = any_oe | oe;
    end
    check(tag, 32'(any_oe), 32'd0);
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input int n, input bit fst);
    logic [7:0] d;
    logic       aoe;
    send_hdr(fst ? 8'h0B : 8'h03, a, ADDR_BITS);
    if (fst) idle_cycles($sformatf("%s_dummy_oe", tag), 8);
    for (int k = 0; k < n; k++) begin
      read_byte(d, aoe);
      check($sformatf("%s_b%0d", tag, k), 32'(d), 32'(ref_byte(a + 32'(k))));
      check($sformatf("%s_b%0d_oe", tag, k), 32'(aoe), 32'd1);
    end
    end_xfer(tag);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic       aoe, r, oe, any_oe;
    logic [31:0] ra;

    bus.cs = 1'b1; bus.sclk = 1'b0; bus.si = 1'b0; bus.wp = 1'b1; bus.hold = 1'b1;
    img[0] = 8'h85; img[1] = 8'h44; img[2] = 8'hA6; img[3] = 8'h14;
    img[4] = 8'h05; img[5] = 8'h49; img[6] = 8'hB7; img[7] = 8'h99;
    for (int i = 8; i < NB; i++) img[i] = 8'($urandom);
    for (int i = 0; i < NB; i++) buffer[i*8 +: 8] = img[i];

    repeat (2) @(negedge clk);
    check("reset_oe", 32'(bus.so_oe), 32'd0);
    rstn = 1'b1;
    repeat (HALF) @(negedge clk);

    read_check("rd0", 32'h0, 4, 1'b0);
    read_check("cont3", 32'h3, 5, 1'b0);
    read_check("oor", 32'(NB-1), 2, 1'b0);
    read_check("wrap", 32'hFFFFFF, 2, 1'b0);

    // Abort after 12 address bits, then a clean read
    send_hdr(8'h03, 32'h0, 12);
    end_xfer("abort");
    read_check("after_abort", 32'h4, 1, 1'b0);

    // Unknown opcode keeps so released
    send_hdr(8'h9F, 32'h0, 0);
    idle_cycles("op9f_oe", 32);
    end_xfer("op9f");

    // Hold during byte 1 of a read at 0
    send_hdr(8'h03, 32'h0, ADDR_BITS);
    read_byte(d, aoe);
    check("hold_b0", 32'(d), 32'(ref_byte(32'h0)));
    for (int i = 7; i >= 5; i--) begin spi_cycle(1'b0, r, oe); d[i] = r; end
    repeat (HALF) @(negedge clk);
    bus.hold = 1'b0;
    repeat (HALF) @(negedge clk);
    check("hold_oe_low", 32'(bus.so_oe), 32'd0);
    any_oe = 1'b0;
    for (int i = 0; i < 10; i++) begin spi_cycle(1'($urandom_range(0, 1)), r, oe); any_oe = any_oe | oe; end
    check("hold_oe_held", 32'(any_oe), 32'd0);
    repeat (HALF) @(negedge clk);
    bus.hold = 1'b1;
    repeat (HALF) @(negedge clk);
    for (int i = 4; i >= 0; i--) begin spi_cycle(1'b0, r, oe); d[i] = r; end
    check("hold_b1", 32'(d), 32'(ref_byte(32'h1)));
    read_byte(d, aoe);
    check("hold_b2", 32'(d), 32'(ref_byte(32'h2)));
    end_xfer("hold");

    // Reset mid-transaction with cs held low: no activity until a new cs fall
    send_hdr(8'h03, 32'h0, ADDR_BITS);
    read_byte(d, aoe);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    idle_cycles("midrst_oe", 16);
    end_xfer("midrst");
    read_check("after_rst", 32'h1, 2, 1'b0);

    // Randomized reads, biased toward the end of the image
    for (int t = 0; t < 6; t++) begin
      if (t % 2 == 0) ra = 32'($urandom_range(0, NB-1));
      else            ra = 32'($urandom_range(NB-3, NB+2));
      read_check($sformatf("rnd%0d", t), ra, int'($urandom_range(1, 4)), 1'b0);
    end

`ifdef FLASH_MOCK_FAST_READ_EN
    read_check("fast", 32'h0, 2, 1'b1);
`else
    send_hdr(8'h0B, 32'h0, 0);
    idle_cycles("fast_off_oe", 32);
    end_xfer("fast_off");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_buffer_mock.md
Name: spi_flash_buffer_mock

Overview:
Behavioural-but-synthesizable model of a serial (single-I/O) SPI NOR flash whose contents come from a flat parameterised bit-vector input. It sits beside the SoC top in post-synthesis benches and serves boot code to the flash controller over cs/sclk/si/so. The model is clocked by a fast system clock that oversamples the SPI pins. It supports the READ (0x03) command in SPI mode 0.

Parameters:
BUFFER_SIZE, 8192, buffer width in bits; must be a multiple of 8.
ADDR_BITS, 24, flash address width in bits.

Ports:
clk  in  1  system oversampling clock; must run at least 4x the sclk frequency.
rstn  in  1  synchronous, active-low reset.
cs  in  1  chip select, active low.
sclk  in  1  SPI clock driven by the controller.
si  in  1  controller-to-flash data (MOSI).
so  out  1  flash-to-controller data (MISO); high-Z when not in the data phase.
wp  in  1  write protect; ignored, since the model is read-only.
hold  in  1  active-low hold.
buffer  in  BUFFER_SIZE  flash contents; byte at address A = buffer[8A+7:8A].

Behaviour:
- Synchronisation: cs, sclk, si and hold each pass through a 2-flop synchroniser on clk. sclk rise/fall are detected from the synchronised sample.
- SPI mode 0:
  - si is sampled on the sclk rising edge.
  - so changes after the sclk falling edge.
  - Bits are MSB first within each byte.
- so latency: so updates at most 3 clk cycles after the sclk falling edge.
- States:
  - IDLE: entered on reset or cs high.
  - CMD: 8 bits.
  - ADDR: ADDR_BITS bits, MSB first.
  - DATA.
  - IGNORE.
- Transitions:
  - cs falling: IDLE->CMD, with the bit counter cleared.
  - 8th CMD rise, opcode 0x03: ->ADDR.
  - 8th CMD rise, any other opcode: ->IGNORE.
  - Last ADDR rise: latch the address. The following sclk fall drives bit 7 of that byte; ->DATA.
  - DATA: each fall shifts out the next bit. After bit 0, the address increments by 1 and the next byte begins with no gap (continuous read).
  - Address increment wraps modulo 2^ADDR_BITS.
  - Addresses >= BUFFER_SIZE/8 return 0xFF (erased flash).
  - cs high, in any state: ->IDLE within 3 clk cycles; so goes high-Z and the partial command is discarded.
  - IGNORE: so stays high-Z until cs rises.
- hold: while synchronised hold=0, sclk edges are ignored, all state is frozen and so is high-Z. Operation resumes where it left off.
- Reset: state=IDLE, counters=0, shift registers=0, so high-Z. rstn low mid-transaction aborts it; the next access requires a new cs falling edge.
- buffer is read combinationally by byte index; the model has no internal storage of contents.

Optional Feature:
FLASH_MOCK_FAST_READ_EN
- Defined: opcode 0x0B is accepted. The ADDR state is followed by a DUMMY state of 8 sclk cycles, during which so is high-Z, then DATA exactly as for 0x03.
- Undefined: 0x0B is treated as unknown and goes to IGNORE.

Decomposition:
- Package spi_flash_mock_pkg holds:
  - OPC_READ=8'h03 and OPC_FAST_READ=8'h0B.
  - DUMMY_CYCLES=8.
  - A state enum typedef {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE}.
- One sub-module, spi_pin_sync, provides the 2-flop synchroniser plus edge detector for sclk/cs/si/hold. It outputs the synchronised levels plus sclk_rise and sclk_fall pulses.

Test Plan:
All scenarios use a buffer whose first words are 'h14a64485 and 'h99b74905 (little-endian).
- Reset: rstn=0 for 2 clk, then cs low, 0x03, addr 0x000000, 32 data clocks -> so bytes 0x85, 0x44, 0xA6, 0x14; so high-Z after cs high.
- Continuous read: 0x03 at addr 0x000003, 5 bytes -> 0x14, 0x05, 0x49, 0xB7, 0x99.
- Out of range: 0x03 at addr BUFFER_SIZE/8-1, 2 bytes -> last buffer byte, then 0xFF.
- Abort and unknown opcode:
  - cs raised after 12 address bits, then a fresh 0x03 at 0x000004 -> 0x05. No leftover state.
  - Opcode 0x9F -> so stays high-Z for 32 clocks.
- Hold: hold=0 for 10 sclk periods during byte 1 of a read at 0 -> stream resumes intact (0x85, 0x44, ...); so high-Z while held.
- FLASH_MOCK_FAST_READ_EN: 0x0B at 0x000000 plus 8 dummy clocks -> 0x85, 0x44. Without the macro -> high-Z.
